// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RISC-V widths, reset vector and fetch-entry type
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
    return a & ~XLEN'(3);
  endfunction
endpackage

// File: rtl/riscv_ifetch_fifo.sv
// riscv_ifetch_fifo: 2-entry {pc, inst} queue with push, pop and flush
module riscv_ifetch_fifo import riscv_pkg::*; (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic                 flush,
  input  logic [XLEN+ILEN-1:0] din,
  output logic [XLEN+ILEN-1:0] dout,
  output logic [1:0]           count
);
  logic [XLEN+ILEN-1:0] mem [2];
  logic wp, rp, do_push, do_pop;
  assign do_pop = pop && count != 2'd0;
  assign do_push = push && (count != 2'd2 || do_pop);
  assign dout = mem[rp];
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp <= 1'b0;
      rp <= 1'b0;
      count <= 2'd0;
    end else begin
      wp <= wp ^ do_push;
      rp <= rp ^ do_pop;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end
endmodule

// File: rtl/riscv_ifetch.sv
// riscv_ifetch: credit-limited instruction fetch with redirect and stale-response dropping
module riscv_ifetch import riscv_pkg::*; #(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc
);
  logic [XLEN-1:0] pc, rsp_pc;
  logic [1:0] outstanding, stale, fifo_count, out_next;
  logic req_fire, push, pop;
  logic [XLEN+ILEN-1:0] head_bits;
  fetch_entry_t head;
  assign imem_req_valid = !rst && ({1'b0, outstanding} + {1'b0, fifo_count} < 3'd2);
  assign imem_req_addr = pc;
  assign req_fire = imem_req_valid && imem_req_ready;
  // live requests are consecutive and end at pc-4, so the oldest sits outstanding words back
  assign rsp_pc = pc - XLEN'({outstanding, 2'b00});
  assign push = imem_rsp_valid && stale == 2'd0 && !redirect_valid;
  assign pop = inst_valid && inst_ready;
  assign out_next = outstanding + 2'(req_fire) - 2'(imem_rsp_valid);
  assign inst_valid = fifo_count != 2'd0;
  assign head = fetch_entry_t'(head_bits);
  assign inst = inst_valid ? head.inst : '0;
  assign inst_pc = inst_valid ? head.pc : '0;
  riscv_ifetch_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   ({rsp_pc, imem_rsp_data}),
    .dout  (head_bits),
    .count (fifo_count)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= word_align(RESET_PC);
      outstanding <= 2'd0;
      stale <= 2'd0;
    end else begin
      outstanding <= out_next;
      pc <= redirect_valid ? word_align(redirect_pc) : req_fire ? pc + XLEN'(4) : pc;
      stale <= redirect_valid ? out_next : stale - 2'(imem_rsp_valid && stale != 2'd0);
    end
  end
endmodule

// File: tb/tb_riscv_ifetch.sv
// tb_riscv_ifetch: randomized in-order memory model and fetch-stream scoreboard
module tb_riscv_ifetch;
  logic clk = 1'b0, rst = 1'b1;
  logic imem_req_valid, imem_req_ready = 1'b0, imem_rsp_valid = 1'b0;
  logic [31:0] imem_req_addr, imem_rsp_data = '0, imem_rsp_data2 = '0;
  logic redirect_valid = 1'b0, inst_ready = 1'b0, inst_valid;
  logic [31:0] redirect_pc = '0, inst, inst_pc;
  logic imem_req_valid2, inst_valid2;
  logic [31:0] imem_req_addr2, inst2, inst_pc2;
  int tests = 0, fails = 0;
  int unsigned cyc = 0, lat_lo = 1, lat_hi = 1;
  typedef struct {
    logic [31:0] a0;
    logic [31:0] a1;
    int unsigned due;
  } mreq_t;
  mreq_t mq[$];
  logic req_v, req_hs, pop_v, pop2_v, redir;
  logic [31:0] req_a, pop_pc, pop_i, pop2_pc, pop2_i, redir_pc;

  riscv_ifetch dut (
    .clk(clk), .rst(rst), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
  );
  riscv_ifetch #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst(rst), .imem_req_valid(imem_req_valid2), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr2), .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data2),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .inst_valid(inst_valid2),
    .inst_ready(inst_ready), .inst(inst2), .inst_pc(inst_pc2)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5a3c, a[31:16]} ^ 32'h0f0f_1234;
  endfunction

  // one clock: sample handshakes mid-cycle, then drive the memory response for the new cycle
  task automatic tick();
    logic rst_s;
    @(negedge clk);
    req_v = imem_req_valid;
    req_a = imem_req_addr;
    req_hs = imem_req_valid && imem_req_ready;
    pop_v = inst_valid && inst_ready;
    pop_pc = inst_pc;
    pop_i = inst;
    pop2_v = inst_valid2 && inst_ready;
    pop2_pc = inst_pc2;
    pop2_i = inst2;
    redir = redirect_valid;
    redir_pc = redirect_pc;
    rst_s = rst;
    if (imem_rsp_valid && mq.size() > 0) mq.delete(0);
    if (req_hs) mq.push_back('{imem_req_addr, imem_req_addr2, cyc + $urandom_range(lat_hi, lat_lo)});
    @(posedge clk);
    cyc++;
    #1;
    if (rst_s) mq.delete();
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data = mem_word(mq[0].a0);
      imem_rsp_data2 = mem_word(mq[0].a1);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data = $urandom;
      imem_rsp_data2 = $urandom;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    tick();
    tick();
    tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL reset_req_valid got %b exp 0", imem_req_valid); end
    tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL reset_inst_valid got %b exp 0", inst_valid); end
    tests++; if (inst !== 32'h0 || inst_pc !== 32'h0) begin fails++; $display("FAIL reset_inst got %h/%h exp 0/0", inst, inst_pc); end
    rst = 1'b0;
    #1;
    tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin fails++; $display("FAIL reset_first_req got %b/%h exp 1/00000000", imem_req_valid, imem_req_addr); end
    tests++; if (imem_req_addr2 !== 32'hFFFF_FFF8) begin fails++; $display("FAIL reset_pc_param got %h exp fffffff8", imem_req_addr2); end
  endtask

  task automatic test_stream();
    logic [31:0] rq[$], pp[$], pd[$];
    do_reset();
    lat_lo = 1; lat_hi = 1;
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    for (int i = 0; i < 20 && pp.size() < 3; i++) begin
      tick();
      if (req_hs) rq.push_back(req_a);
      if (pop_v) begin pp.push_back(pop_pc); pd.push_back(pop_i); end
    end
    tests++;
    if (pp.size() < 3 || rq.size() < 3) begin
      fails++; $display("FAIL stream_count got %0d pops %0d reqs exp 3/3", pp.size(), rq.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++; if (rq[i] !== 32'(i * 4)) begin fails++; $display("FAIL stream_req%0d got %h exp %h", i, rq[i], 32'(i * 4)); end
        tests++; if (pp[i] !== 32'(i * 4) || pd[i] !== mem_word(32'(i * 4))) begin fails++; $display("FAIL stream_inst%0d got %h/%h exp %h/%h", i, pp[i], pd[i], 32'(i * 4), mem_word(32'(i * 4))); end
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] pp[$], pd[$];
    logic [31:0] exp_pc[3];
    exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0;
    do_reset();
    lat_lo = 1; lat_hi = 2;
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    for (int i = 0; i < 30 && pp.size() < 3; i++) begin
      tick();
      if (pop2_v) begin pp.push_back(pop2_pc); pd.push_back(pop2_i); end
    end
    tests++;
    if (pp.size() < 3) begin
      fails++; $display("FAIL wrap_count got %0d exp 3", pp.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++; if (pp[i] !== exp_pc[i] || pd[i] !== mem_word(exp_pc[i])) begin fails++; $display("FAIL wrap_inst%0d got %h/%h exp %h/%h", i, pp[i], pd[i], exp_pc[i], mem_word(exp_pc[i])); end
      end
    end
  endtask

  task automatic test_backpressure();
    int nreq = 0;
    do_reset();
    lat_lo = 1; lat_hi = 1;
    imem_req_ready = 1'b1;
    inst_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (req_hs) nreq++;
    end
    tests++; if (nreq != 2) begin fails++; $display("FAIL bp_req_count got %0d exp 2", nreq); end
    tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL bp_req_valid got %b exp 0", imem_req_valid); end
    tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== mem_word(32'h0)) begin fails++; $display("FAIL bp_head got %b/%h/%h exp 1/00000000/%h", inst_valid, inst_pc, inst, mem_word(32'h0)); end
    inst_ready = 1'b1;
    tick();
    tests++; if (req_v !== 1'b0) begin fails++; $display("FAIL bp_no_comb_credit got %b exp 0", req_v); end
    tests++; if (pop_v !== 1'b1 || pop_pc !== 32'h0) begin fails++; $display("FAIL bp_pop0 got %b/%h exp 1/00000000", pop_v, pop_pc); end
    tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8) begin fails++; $display("FAIL bp_next_req got %b/%h exp 1/00000008", imem_req_valid, imem_req_addr); end
    tests++; if (inst_valid !== 1'b1 || inst_pc !== 32'h4 || inst !== mem_word(32'h4)) begin fails++; $display("FAIL bp_second got %b/%h/%h exp 1/00000004/%h", inst_valid, inst_pc, inst, mem_word(32'h4)); end
  endtask

  task automatic test_redirect();
    logic got_req = 1'b0, got_pop = 1'b0;
    logic [31:0] first_req = '0, first_pc = '0, first_i = '0;
    do_reset();
    lat_lo = 3; lat_hi = 3;
    imem_req_ready = 1'b1;
    inst_ready = 1'b1;
    tick();
    tick();
    tests++; if (imem_req_valid !== 1'b0 || mq.size() != 2) begin fails++; $display("FAIL redir_setup got %b/%0d exp 0/2", imem_req_valid, mq.size()); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_1003;
    tick();
    redirect_valid = 1'b0;
    tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL redir_inst_valid got %b exp 0", inst_valid); end
    for (int i = 0; i < 30 && !got_pop; i++) begin
      tick();
      if (req_hs && !got_req) begin got_req = 1'b1; first_req = req_a; end
      if (pop_v) begin got_pop = 1'b1; first_pc = pop_pc; first_i = pop_i; end
    end
    tests++; if (!got_req || first_req !== 32'h1000) begin fails++; $display("FAIL redir_first_req got %b/%h exp 1/00001000", got_req, first_req); end
    tests++; if (!got_pop || first_pc !== 32'h1000 || first_i !== mem_word(32'h1000)) begin fails++; $display("FAIL redir_first_inst got %b/%h/%h exp 1/00001000/%h", got_pop, first_pc, first_i, mem_word(32'h1000)); end
  endtask

  task automatic test_reset_midstream();
    logic got_pop = 1'b0;
    do_reset();
    lat_lo = 1; lat_hi = 1;
    imem_req_ready = 1'b1;
    inst_ready = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    tests++; if (inst_valid !== 1'b1) begin fails++; $display("FAIL mid_full got %b exp 1", inst_valid); end
    rst = 1'b1;
    tick();
    tests++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0) begin fails++; $display("FAIL mid_reset got %b/%b exp 0/0", inst_valid, imem_req_valid); end
    rst = 1'b0;
    #1;
    tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin fails++; $display("FAIL mid_first_req got %b/%h exp 1/00000000", imem_req_valid, imem_req_addr); end
    inst_ready = 1'b1;
    for (int i = 0; i < 20 && !got_pop; i++) begin
      tick();
      if (pop_v) begin
        got_pop = 1'b1;
        tests++; if (pop_pc !== 32'h0 || pop_i !== mem_word(32'h0)) begin fails++; $display("FAIL mid_first_inst got %h/%h exp 00000000/%h", pop_pc, pop_i, mem_word(32'h0)); end
      end
    end
    tests++; if (!got_pop) begin fails++; $display("FAIL mid_timeout got 0 pops exp 1"); end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc = 32'h0, exp_req = 32'h0;
    int npop = 0;
    do_reset();
    lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 3000; i++) begin
      imem_req_ready = $urandom_range(3, 0) != 0;
      inst_ready = $urandom_range(3, 0) != 0;
      redirect_valid = !redirect_valid && $urandom_range(25, 0) == 0;
      redirect_pc = $urandom;
      tick();
      if (req_v) begin
        tests++; if (req_a !== exp_req) begin fails++; $display("FAIL rnd_req_addr cyc %0d got %h exp %h", cyc, req_a, exp_req); end
      end
      if (redir) exp_req = {redir_pc[31:2], 2'b00};
      else if (req_hs) exp_req = exp_req + 32'd4;
      if (pop_v) begin
        npop++;
        tests++; if (pop_pc !== exp_pc || pop_i !== mem_word(exp_pc)) begin fails++; $display("FAIL rnd_inst cyc %0d got %h/%h exp %h/%h", cyc, pop_pc, pop_i, exp_pc, mem_word(exp_pc)); end
        exp_pc = exp_pc + 32'd4;
      end
      if (redir) begin
        exp_pc = {redir_pc[31:2], 2'b00};
        tests++; if (inst_valid !== 1'b0) begin fails++; $display("FAIL rnd_post_redirect cyc %0d got %b exp 0", cyc, inst_valid); end
      end
      if (!inst_valid) begin
        tests++; if (inst !== 32'h0 || inst_pc !== 32'h0) begin fails++; $display("FAIL rnd_idle_zero cyc %0d got %h/%h exp 0/0", cyc, inst, inst_pc); end
      end
    end
    redirect_valid = 1'b0;
    tests++; if (npop < 200) begin fails++; $display("FAIL rnd_progress got %0d pops exp >=200", npop); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_wrap();
    test_backpressure();
    test_redirect();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
